// File: rtl/vending_machine_pkg.sv
// Shared types and constants for the vending machine: state encoding,
// coin encodings, product price and a coin-to-units helper.
package vending_machine_pkg;

    // Credit held between coins; the encoding equals the credit in units
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_ONE  = 2'b01;
    localparam logic [1:0] COIN_TWO  = 2'b10;
    localparam logic [1:0] COIN_INV  = 2'b11;

    // Price in units; width covers the largest reachable credit (2 + 2)
    localparam logic [2:0] PRICE = 3'd3;

    // Units of credit carried by one coin code; the invalid code adds nothing
    function automatic logic [1:0] coin_units(input logic [1:0] coin);
        logic [1:0] units;
        case (coin)
            COIN_ONE:  units = 2'd1;
            COIN_TWO:  units = 2'd2;
            COIN_NONE: units = 2'd0;
            COIN_INV:  units = 2'd0;
            default:   units = 2'd0;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/vm_sale_counter.sv
// Saturating count of vends. Only instantiated when
// VENDING_MACHINE_SALE_CNT_EN is defined.
module vm_sale_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count one per vend, hold at all-ones; reset (active high) clears
    always_ff @(posedge clk) begin
        if (rstn) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vending_machine.sv
// Three-unit vending machine accepting one- and two-unit coins.
// pr pulses for one cycle on the edge that completes a purchase, ch
// pulses with it when four units were inserted.
// Optional feature: define VENDING_MACHINE_SALE_CNT_EN to add the
// saturating sale_cnt output (CNT_W bits).
// Note: rstn is an active-high synchronous reset despite its name.
module vending_machine
    import vending_machine_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       coin,
    output logic             pr,
`ifdef VENDING_MACHINE_SALE_CNT_EN
    output logic             ch,
    output logic [CNT_W-1:0] sale_cnt
`else
    output logic             ch
`endif
);

    state_t     state_reg;
    state_t     state_next;
    logic [2:0] credit_sum;
    logic       vend_next;
    logic       change_next;

    // Add the incoming coin to the held credit and decide whether it completes a sale
    always_comb begin
        credit_sum  = {1'b0, state_reg} + {1'b0, coin_units(coin)};
        vend_next   = 1'b0;
        change_next = 1'b0;
        state_next  = state_reg;
        if (credit_sum >= PRICE) begin
            // Any completed sale leaves no credit behind
            vend_next   = 1'b1;
            change_next = (credit_sum == PRICE + 3'd1);
            state_next  = S0;
        end else begin
            state_next  = state_t'(credit_sum[1:0]);
        end
    end

    // State register with registered dispense/change pulses; reset wins over any coin
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_reg <= S0;
            pr        <= 1'b0;
            ch        <= 1'b0;
        end else begin
            state_reg <= state_next;
            pr        <= vend_next;
            ch        <= change_next;
        end
    end

`ifdef VENDING_MACHINE_SALE_CNT_EN
    // The counter steps on the same edge that raises pr
    vm_sale_counter #(
        .CNT_W (CNT_W)
    ) u_sale_counter (
        .clk  (clk),
        .rstn (rstn),
        .inc  (vend_next),
        .cnt  (sale_cnt)
    );
`else
    // Keeps CNT_W referenced when the counter is compiled out
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench for vending_machine. The stimulus process drives one
// reset/coin pair per cycle and pushes the expected pulses computed from
// a credit-arithmetic model; a monitor pops and compares after every edge.
// With VENDING_MACHINE_SALE_CNT_EN defined, sale_cnt is also checked on
// an 8-bit and a 2-bit (saturating) instance driven by the same stimulus.
module tb_vending_machine;

    logic       clk;
    logic       rstn;
    logic [1:0] coin;
    logic       pr;
    logic       ch;
`ifdef VENDING_MACHINE_SALE_CNT_EN
    logic [7:0] sale_cnt;
    logic       pr2;
    logic       ch2;
    logic [1:0] sale_cnt2;
`endif

    typedef struct {
        logic rst;
        logic [1:0] coin;
        logic pr;
        logic ch;
        int   cnt8;
        int   cnt2;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    // Reference model state: credit in units and sale counts
    int model_credit = 0;
    int model_cnt8   = 0;
    int model_cnt2   = 0;

`ifdef VENDING_MACHINE_SALE_CNT_EN
    vending_machine #(.CNT_W(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .coin     (coin),
        .pr       (pr),
        .ch       (ch),
        .sale_cnt (sale_cnt)
    );
    vending_machine #(.CNT_W(2)) dut2 (
        .clk      (clk),
        .rstn     (rstn),
        .coin     (coin),
        .pr       (pr2),
        .ch       (ch2),
        .sale_cnt (sale_cnt2)
    );
`else
    vending_machine #(.CNT_W(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .coin (coin),
        .pr   (pr),
        .ch   (ch)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply the model to one cycle's inputs and queue what the DUT must show after the edge
    task automatic push_expect(input logic r, input logic [1:0] c);
        exp_t e;
        int   units;
        e.rst  = r;
        e.coin = c;
        e.pr   = 1'b0;
        e.ch   = 1'b0;
        if (r) begin
            model_credit = 0;
            model_cnt8   = 0;
            model_cnt2   = 0;
        end else begin
            units = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
            model_credit += units;
            if (model_credit >= 3) begin
                e.pr = 1'b1;
                e.ch = (model_credit == 4);
                model_credit = 0;
                if (model_cnt8 < 255) model_cnt8++;
                if (model_cnt2 < 3)   model_cnt2++;
            end
        end
        e.cnt8 = model_cnt8;
        e.cnt2 = model_cnt2;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus away from the sampling edge
    task automatic step(input logic r, input logic [1:0] c);
        @(negedge clk);
        rstn = r;
        coin = c;
        push_expect(r, c);
    endtask

    // Monitor: after each rising edge, pop one expectation and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d rst=%0b coin=%02b pr=%0b ch=%0b", txn, e.rst, e.coin, pr, ch);
                total++;
                if (pr !== e.pr) begin
                    bad++;
                    $display("FAIL pr txn=%0d got=%0b want=%0b", txn, pr, e.pr);
                end
                total++;
                if (ch !== e.ch) begin
                    bad++;
                    $display("FAIL ch txn=%0d got=%0b want=%0b", txn, ch, e.ch);
                end
`ifdef VENDING_MACHINE_SALE_CNT_EN
                total++;
                if (int'(sale_cnt) != e.cnt8 || $isunknown(sale_cnt)) begin
                    bad++;
                    $display("FAIL sale_cnt txn=%0d got=%0d want=%0d", txn, sale_cnt, e.cnt8);
                end
                total++;
                if (int'(sale_cnt2) != e.cnt2 || $isunknown(sale_cnt2)) begin
                    bad++;
                    $display("FAIL sale_cnt_sat txn=%0d got=%0d want=%0d", txn, sale_cnt2, e.cnt2);
                end
                total++;
                if (pr2 !== e.pr || ch2 !== e.ch) begin
                    bad++;
                    $display("FAIL pr_ch_w2 txn=%0d got=%0b%0b want=%0b%0b", txn, pr2, ch2, e.pr, e.ch);
                end
`endif
            end
        end
    end

    // Stimulus: directed purchase sequences, then randomized coins with occasional resets
    initial begin
        int wait_cycles;
        rstn = 1'b1;
        coin = 2'b00;
        push_expect(1'b1, 2'b00);

        // Three single-unit coins
        step(1, 2'b00);
        step(0, 2'b01); step(0, 2'b01); step(0, 2'b01); step(0, 2'b00);
        // 1+1+2 -> change
        step(1, 2'b00);
        step(0, 2'b01); step(0, 2'b01); step(0, 2'b10); step(0, 2'b00);
        // 2+1 and 2+2
        step(1, 2'b00);
        step(0, 2'b10); step(0, 2'b01); step(0, 2'b00);
        step(1, 2'b00);
        step(0, 2'b10); step(0, 2'b10); step(0, 2'b00);
        // Idle and invalid coins add nothing
        step(1, 2'b00);
        step(0, 2'b01); step(0, 2'b11); step(0, 2'b00); step(0, 2'b01); step(0, 2'b01);
        step(0, 2'b00);
        // Reset mid-purchase discards credit and the coin in that cycle
        step(0, 2'b10); step(1, 2'b01); step(0, 2'b01); step(0, 2'b01); step(0, 2'b01);
        step(0, 2'b00);
        // Five back-to-back 1+2 purchases (counter saturation on the 2-bit instance)
        step(1, 2'b00);
        for (int i = 0; i < 5; i++) begin
            step(0, 2'b01);
            step(0, 2'b10);
        end
        // Consecutive-cycle purchases: 2+2, 1+2 with no idle gap
        step(0, 2'b10); step(0, 2'b10); step(0, 2'b01); step(0, 2'b10);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)));
        end
        step(0, 2'b00);

        // Let the monitor drain the queue, bounded
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vending_machine.md
VENDING_MACHINE -- requirements
Module: vending_machine

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 8, width of the optional sale counter.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic updates on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit, reset; it is synchronous and active-high (1 = reset) despite the name.
REQ-004 The block SHALL have port coin, input, 2 bits, coin per cycle: 00 none, 01 one unit, 10 two units, 11 invalid.
REQ-005 The block SHALL have port pr, output, 1 bit, product-dispense pulse.
REQ-006 The block SHALL have port ch, output, 1 bit, one-unit change-return pulse.
REQ-007 The block SHALL have port sale_cnt, output, CNT_W bits, vend count; present only with VENDING_MACHINE_SALE_CNT_EN.

Function
REQ-008 The product price SHALL be 3 units; coin is sampled on every rising clk edge, with one coin per cycle at most.
REQ-009 The state machine SHALL have states S0 (0 credit), S1 (1 unit credit) and S2 (2 units credit).
REQ-010 Transitions on coin 01 SHALL be: S0->S1, S1->S2, S2->S0 with vend.
REQ-011 Transitions on coin 10 SHALL be: S0->S2, S1->S0 with vend, S2->S0 with vend and change.
REQ-012 On coin 00 or 11 the state SHALL be held and neither output asserted; coin 11 adds no credit.
REQ-013 pr and ch SHALL be registered; on the edge accepting the completing coin, pr=1, and ch=1 if credit reached 4, for exactly one cycle; otherwise both are 0.
REQ-014 Latency SHALL be one cycle: a completing coin sampled at edge k gives pr high from edge k to edge k+1.
REQ-015 ch SHALL never assert without pr in the same cycle.
REQ-016 After any vend, the next cycle SHALL start from S0; back-to-back purchases in consecutive cycles SHALL be supported.

Reset
REQ-017 While rstn=1 at a rising edge: state=S0, pr=0, ch=0, and sale_cnt=0 if present.
REQ-018 Reset SHALL take priority over coin; a coin in a reset cycle is discarded, including mid-purchase.
REQ-019 The first coin SHALL be accepted on the first edge with rstn=0.

Configuration
REQ-020 Macro VENDING_MACHINE_SALE_CNT_EN defined: sale_cnt SHALL increment by 1 on each edge that asserts pr and saturate at all-ones.
REQ-021 Macro undefined: port sale_cnt and its logic SHALL be absent; pr/ch behaviour is identical.

Structure
REQ-022 Package vending_machine_pkg SHALL hold the state enum (S0, S1, S2), coin encodings (COIN_NONE, COIN_ONE, COIN_TWO, COIN_INV) and the PRICE=3 constant.
REQ-023 The optional counter SHALL be sub-module vm_sale_counter (clk, rstn, inc, cnt), instantiated only under the macro.

Verification
REQ-024 Reset, then coins 01,01,01 on three edges -> pr=1, ch=0 for one cycle after the third edge; state S0.
REQ-025 Reset, then coins 01,01,10 -> pr=1, ch=1 for one cycle after the third edge.
REQ-026 Reset, then coins 10,01 -> pr=1, ch=0 after the second edge; reset, then coins 10,10 -> pr=1, ch=1 after the second edge.
REQ-027 Coins 01,11,00,01,01 -> no output until the fifth edge, then pr=1, ch=0.
REQ-028 Coins 10, then rstn=1 with coin 01, then coin 01 -> no vend; state S1 after the last edge.
REQ-029 With macro: five 01,10 purchases -> sale_cnt=5; with CNT_W=2, five purchases -> sale_cnt=3 (saturated).
